// File: rtl/blink_pkg.sv
// Shared constants and helpers for the blink RGB blinker.
// Default counter tap positions and a max-of-three used to size the counter.
package blink_pkg;

  localparam int R_BIT_DEF = 22;
  localparam int G_BIT_DEF = 23;
  localparam int B_BIT_DEF = 24;
  localparam int D_BIT_DEF = 4;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/blink_pwm.sv
// One LED channel: gate with optional PWM dimming, registered output.
// Dimming comparator is compiled in only when BLINK_DIM_EN is defined.
module blink_pwm
  import blink_pkg::*;
#(
  parameter int d_bit = D_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate,
  input  logic [d_bit-1:0] duty,
  input  logic [d_bit-1:0] phase,
  output logic             led
);

  logic nxt;

`ifdef BLINK_DIM_EN
  always_comb begin
    nxt = gate & (phase < duty);
  end
`else
  logic unused_pwm;

  assign unused_pwm = ^{duty, phase};

  always_comb begin
    nxt = gate;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led <= 1'b0;
    end else begin
      led <= nxt;
    end
  end

endmodule

// File: rtl/blink.sv
// Free-running counter driving three blinking (optionally dimmed) LEDs.
// Define BLINK_DIM_EN to build in PWM dimming; default build is plain blink.
module blink
  import blink_pkg::*;
#(
  parameter int r_bit = R_BIT_DEF,
  parameter int g_bit = G_BIT_DEF,
  parameter int b_bit = B_BIT_DEF,
  parameter int d_bit = D_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic led_r,
  output logic led_g,
  output logic led_b
);

  localparam int CNT_W = max3(r_bit, g_bit, b_bit) + 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Duty field sits directly below each gate bit and must not overlap phase.
  if (d_bit < 1 ||
      r_bit < 2 * d_bit ||
      g_bit < 2 * d_bit ||
      b_bit < 2 * d_bit) begin : g_bad_param
    $error("blink: illegal r_bit/g_bit/b_bit/d_bit combination");
  end

  logic [CNT_W-1:0] count;
  logic [d_bit-1:0] phase;
  logic             unused_count;

  assign phase        = count[d_bit-1:0];
  assign unused_count = ^count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

  blink_pwm #(
    .d_bit(d_bit)
  ) u_pwm_r (
    .clk  (clk),
    .rst  (rst),
    .gate (count[r_bit]),
    .duty (count[r_bit-1 -: d_bit]),
    .phase(phase),
    .led  (led_r)
  );

  blink_pwm #(
    .d_bit(d_bit)
  ) u_pwm_g (
    .clk  (clk),
    .rst  (rst),
    .gate (count[g_bit]),
    .duty (count[g_bit-1 -: d_bit]),
    .phase(phase),
    .led  (led_g)
  );

  blink_pwm #(
    .d_bit(d_bit)
  ) u_pwm_b (
    .clk  (clk),
    .rst  (rst),
    .gate (count[b_bit]),
    .duty (count[b_bit-1 -: d_bit]),
    .phase(phase),
    .led  (led_b)
  );

endmodule

// File: tb/tb_blink.sv
// Directed testbench for blink with a small 12-bit counter.
// Expected values are hand-derived; a tiny count model tracks LED timing.
module tb_blink;

  logic clk;
  logic rst;
  logic led_r;
  logic led_g;
  logic led_b;

  int vecs;
  int errs;

  logic [11:0] mc;
  logic [2:0]  led_m;

  blink #(
    .r_bit(9),
    .g_bit(10),
    .b_bit(11),
    .d_bit(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .led_r(led_r),
    .led_g(led_g),
    .led_b(led_b)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2:0] exp_led(input logic [11:0] c);
    logic [2:0] g;
    g = {c[11], c[10], c[9]};
`ifdef BLINK_DIM_EN
    g[0] = g[0] & (c[3:0] < c[8:5]);
    g[1] = g[1] & (c[3:0] < c[9:6]);
    g[2] = g[2] & (c[3:0] < c[10:7]);
`endif
    return g;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    led_m = exp_led(mc);
    mc    = mc + 12'd1;
    #1;
  endtask

  task automatic run_to(input logic [11:0] target);
    for (int i = 0; i < 8192 && mc != target; i++) tick();
    check("count_at", 32'(dut.count), 32'(target));
  endtask

  task automatic check_leds(input string tag);
    check(tag, 32'({led_b, led_g, led_r}), 32'(led_m));
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    mc    = '0;
    led_m = '0;
    rst   = 1'b0;

    #1;
    check("rst_cnt_t1", 32'(dut.count), 32'd0);
    check("rst_led_t1", 32'({led_b, led_g, led_r}), 32'd0);
    #9;
    check("rst_cnt_t10", 32'(dut.count), 32'd0);
    check("rst_led_t10", 32'({led_b, led_g, led_r}), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    tick();
    check("first_cnt", 32'(dut.count), 32'd1);
    check("first_led", 32'({led_b, led_g, led_r}), 32'd0);

    run_to(12'd1000);
    check("no_x", 32'($isunknown({led_b, led_g, led_r})), 32'd0);
    for (int i = 0; i < 9000; i++) tick();
    check("cnt_10000", 32'(dut.count), 32'd1808);
    check_leds("led_1808");

`ifdef BLINK_DIM_EN
    run_to(12'h210);
    check("dim_duty0", 32'(led_r), 32'd0);
    run_to(12'h3F4);
    check("dim_on", 32'(led_r), 32'd1);
    run_to(12'h400);
    check("dim_maxph", 32'(led_r), 32'd0);
    run_to(12'd2049);
    check_leds("dim_2049");
`else
    run_to(12'd512);
    check("r_pre_rise", 32'(led_r), 32'd0);
    run_to(12'd513);
    check("r_rise", 32'(led_r), 32'd1);
    run_to(12'd1024);
    check("r_hold", 32'(led_r), 32'd1);
    run_to(12'd1025);
    check("r_fall", 32'(led_r), 32'd0);
    check("g_rise", 32'(led_g), 32'd1);
    run_to(12'd2048);
    check("g_hold", 32'(led_g), 32'd1);
    check("b_low", 32'(led_b), 32'd0);
    run_to(12'd2049);
    check("g_fall", 32'(led_g), 32'd0);
    check("b_rise", 32'(led_b), 32'd1);
`endif

    run_to(12'd4095);
    check_leds("led_4095");
    tick();
    check("wrap_cnt", 32'(dut.count), 32'd0);
    check_leds("wrap_led0");
    tick();
    check("wrap_led1", 32'({led_b, led_g, led_r}), 32'd0);

    run_to(12'd700);
    check_leds("led_700");
    #1;
    rst = 1'b0;
    #0.5;
    mc    = '0;
    led_m = '0;
    check("mid_rst_cnt", 32'(dut.count), 32'd0);
    check("mid_rst_led", 32'({led_b, led_g, led_r}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("mid_hold_cnt", 32'(dut.count), 32'd0);
    rst = 1'b1;
    tick();
    check("resume_cnt", 32'(dut.count), 32'd1);
    check("resume_led", 32'({led_b, led_g, led_r}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
